// File: rtl/dff_pipe_pkg.sv
// Shared defaults and helpers for the dff_pipe_sr register pipeline.
package dff_pipe_pkg;

    localparam int DFF_PIPE_WIDTH_DEF = 8;
    localparam int DFF_PIPE_DEPTH_DEF = 4;

    // Bits needed to count 0..depth occupied stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_en_sr.sv
// One pipeline stage: WIDTH data bits plus a valid bit, with enable and a
// synchronous clear of the valid bit. Data reset exists only when
// DFF_PIPE_DATA_RESET_EN is defined; otherwise the data flops have no reset.
module dff_en_sr
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DFF_PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    // Next state: clear beats enable, and clear never disturbs the data bits.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (en) begin
            data_d = d;
            vld_d  = d_valid;
        end
    end

    // Valid bit always has a reset.
    always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
    end

`ifdef DFF_PIPE_DATA_RESET_EN
    // Data register with reset to RESET_VAL.
    always_ff @(posedge clk) begin
        if (rst) data_q <= RESET_VAL;
        else     data_q <= data_d;
    end
`else
    // Data register without reset; consumers qualify with the valid bit.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    logic unused_reset_val;
    assign unused_reset_val = ^RESET_VAL;
`endif

    assign q       = data_q;
    assign q_valid = vld_q;

endmodule

// File: rtl/dff_pipe_sr.sv
// Stallable WIDTH x DEPTH register pipeline with per-stage valid bits, flush
// and a registered occupancy count. Optional data reset: DFF_PIPE_DATA_RESET_EN.
module dff_pipe_sr
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DFF_PIPE_WIDTH_DEF,
    parameter int               DEPTH     = DFF_PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              d,
    input  logic                          d_valid,
    output logic [WIDTH-1:0]              q,
    output logic                          q_valid,
    output logic [occ_width(DEPTH)-1:0]   occ
);

    localparam int               OCC_W   = occ_width(DEPTH);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    // Index 0 is the pipeline input; index i+1 is the output of stage i.
    logic [WIDTH-1:0] data_pipe [DEPTH+1];
    logic [DEPTH:0]   vld_pipe;

    logic [OCC_W-1:0] occ_q, occ_d;

    assign data_pipe[0] = d;
    assign vld_pipe[0]  = d_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_en_sr #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clr     (flush),
            .d       (data_pipe[i]),
            .d_valid (vld_pipe[i]),
            .q       (data_pipe[i+1]),
            .q_valid (vld_pipe[i+1])
        );
    end

    // Occupancy tracks items entering stage 0 minus the item leaving the last stage.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OCC_W'(vld_pipe[0]) - OCC_W'(vld_pipe[DEPTH]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    assign q       = data_pipe[DEPTH];
    assign q_valid = vld_pipe[DEPTH];
    assign occ     = occ_q;

    // The counter must never leave 0..DEPTH and must equal the live valid bits.
    occ_bounded: assert property (@(posedge clk) disable iff (rst) occ_q <= OCC_MAX);
    occ_matches: assert property (@(posedge clk) disable iff (rst)
                                  occ_q == OCC_W'($countones(vld_pipe[DEPTH:1])));

endmodule

// File: tb/tb_dff_pipe_sr.sv
// Self-checking bench for dff_pipe_sr (WIDTH=8, DEPTH=4). Items accepted into
// the pipe are pushed to a scoreboard queue and popped as they reach q.
module tb_dff_pipe_sr;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, en, flush, d_valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [2:0]       occ;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q [$];

    dff_pipe_sr #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, push accepted item, sample #1 after the edge,
    // pop and compare whenever an enabled edge presents a valid item at q.
    task automatic tick(input logic en_i, input logic flush_i, input logic rst_i,
                        input logic dv_i, input logic [WIDTH-1:0] d_i);
        logic [WIDTH-1:0] exp;
        en = en_i; flush = flush_i; rst = rst_i; d_valid = dv_i; d = d_i;
        if (!rst_i && !flush_i && en_i && dv_i) exp_q.push_back(d_i);
        @(posedge clk);
        #1;
        if (rst_i || flush_i) begin
            exp_q.delete();
        end else if (en_i && q_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: q=%h appeared with nothing expected", q);
            end else begin
                exp = exp_q.pop_front();
                if (q !== exp) begin
                    errors++;
                    $display("FAIL scoreboard_data: q=%h expected %h", q, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
            checks++;
            if (q_valid !== 1'b0 || occ !== 3'd0) begin
                errors++;
                $display("FAIL reset: q_valid=%b occ=%0d expected 0/0", q_valid, occ);
            end
`ifdef DFF_PIPE_DATA_RESET_EN
            checks++;
            if (q !== 8'h00) begin
                errors++;
                $display("FAIL reset_data: q=%h expected 00", q);
            end
`endif
        end
    endtask

    // Four bubble edges empty the pipe.
    task automatic drain();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (occ !== 3'd0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: occ=%0d q_valid=%b expected 0/0", occ, q_valid);
        end
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1, 8'(k));
            checks++;
            if (q_valid !== (k >= 4) || occ !== 3'((k < 4) ? k : 4)) begin
                errors++;
                $display("FAIL streaming edge %0d: q_valid=%b occ=%0d expected %b/%0d",
                         k, q_valid, occ, (k >= 4), (k < 4) ? k : 4);
            end
        end
        for (int j = 1; j <= 4; j++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            checks++;
            if (occ !== 3'(4 - j) || q_valid !== (j <= 3)) begin
                errors++;
                $display("FAIL stream_drain %0d: occ=%0d q_valid=%b expected %0d/%b",
                         j, occ, q_valid, 4 - j, (j <= 3));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
        for (int s = 0; s < 3; s++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
            checks++;
            if (q !== 8'h11 || q_valid !== 1'b1 || occ !== 3'd4) begin
                errors++;
                $display("FAIL stall %0d: q=%h q_valid=%b occ=%0d expected 11/1/4",
                         s, q, q_valid, occ);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h15);
        checks++;
        if (q !== 8'h12 || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: q=%h q_valid=%b expected 12/1", q, q_valid);
        end
        drain();
    endtask

    task automatic test_bubbles();
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 1'b0, ((k - 1) % 2 == 0), 8'(8'hA0 + k - 1));
            checks++;
            if (occ !== ((k >= 3) ? 3'd2 : 3'd1)) begin
                errors++;
                $display("FAIL bubbles_occ edge %0d: occ=%0d expected %0d",
                         k, occ, (k >= 3) ? 2 : 1);
            end
            if (k >= 4) begin
                checks++;
                if (q_valid !== ((k - 4) % 2 == 0)) begin
                    errors++;
                    $display("FAIL bubbles_valid edge %0d: q_valid=%b expected %b",
                             k, q_valid, ((k - 4) % 2 == 0));
                end
            end
            if (k == 5) begin
                checks++;
                if (q !== 8'hA1) begin
                    errors++;
                    $display("FAIL bubbles_invalid_data: q=%h expected a1", q);
                end
            end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h30 + i));
        checks++;
        if (occ !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre: occ=%0d expected 3", occ);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1, 8'h99);
        checks++;
        if (occ !== 3'd0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush: occ=%0d q_valid=%b expected 0/0", occ, q_valid);
        end
        // Data stays put through flush: 30,31,32 walk out as invalid, 99 never shows.
        for (int b = 1; b <= 5; b++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            checks++;
            if (q_valid !== 1'b0 || occ !== 3'd0 || q === 8'h99) begin
                errors++;
                $display("FAIL flush_after %0d: q=%h q_valid=%b occ=%0d", b, q, q_valid, occ);
            end
            if (b == 3) begin
                checks++;
                if (q !== 8'h32) begin
                    errors++;
                    $display("FAIL flush_data_kept: q=%h expected 32", q);
                end
            end
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
        tick(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        checks++;
        if (occ !== 3'd0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL priority_reset: occ=%0d q_valid=%b expected 0/0", occ, q_valid);
        end
`ifdef DFF_PIPE_DATA_RESET_EN
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL priority_reset_data: q=%h expected 00", q);
        end
`endif
        tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
        for (int k = 2; k <= 4; k++) begin
            checks++;
            if (q_valid !== 1'b0) begin
                errors++;
                $display("FAIL priority_early edge %0d: q_valid=%b expected 0", k - 1, q_valid);
            end
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        checks++;
        if (q_valid !== 1'b1 || q !== 8'h5A || occ !== 3'd1) begin
            errors++;
            $display("FAIL priority_first: q=%h q_valid=%b occ=%0d expected 5a/1/1",
                     q, q_valid, occ);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; d_valid = 1'b0; d = '0;
        test_reset();
        test_streaming();
        test_stall();
        test_bubbles();
        test_flush();
        test_priority();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d items never reached q, expected 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
